// File: rtl/clk_rst_manager.sv
// Clock/reset housekeeping: PLL lock synchroniser, lock-qualified stretched
// system reset, NUM_CH programmable tick/square-wave dividers and a heartbeat.
module clk_rst_manager #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DIV_WIDTH    = 16,
    parameter int unsigned RESET_CYCLES = 65536,
    parameter int unsigned HB_BIT       = 23,
    parameter int unsigned USE_LOCK     = 1
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic                        lock_in,
    input  logic                        clear_in,
    input  logic [NUM_CH*DIV_WIDTH-1:0] div_in,
    output logic                        reset_out,
    output logic                        running_out,
    output logic                        lock_lost_out,
    output logic [7:0]                  lock_loss_cnt_out,
    output logic [NUM_CH-1:0]           tick_out,
    output logic [NUM_CH-1:0]           sq_out,
    output logic                        hb_out
);

    localparam int unsigned SCW = $clog2(RESET_CYCLES);
    localparam int unsigned HBW = HB_BIT + 1;
    localparam logic [SCW-1:0] STRETCH_LAST = SCW'(RESET_CYCLES - 1);

    localparam logic [1:0] StHold    = 2'd0;
    localparam logic [1:0] StStretch = 2'd1;
    localparam logic [1:0] StRun     = 2'd2;

    logic [1:0]           lock_sync_q;
    logic                 lock_s;
    logic [1:0]           state_q, state_d;
    logic [SCW-1:0]       scnt_q, scnt_d;
    logic                 loss;
    logic                 reset_q, running_q;
    logic                 lost_q, lost_d;
    logic [7:0]           lcnt_q, lcnt_d;
    logic [HBW-1:0]       hb_q;
    logic [DIV_WIDTH-1:0] cnt_q [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt_d [NUM_CH];
    logic [DIV_WIDTH-1:0] act_q [NUM_CH];
    logic [DIV_WIDTH-1:0] act_d [NUM_CH];
    logic [NUM_CH-1:0]    tick_q, tick_d;
    logic [NUM_CH-1:0]    sq_q, sq_d;

    // Lock is forced high when the PLL lock is not to be trusted
    assign lock_s = (USE_LOCK != 0) ? lock_sync_q[1] : 1'b1;

    // FSM next state, stretch counter and lock-loss bookkeeping
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        loss    = 1'b0;
        unique case (state_q)
            StHold: begin
                if (lock_s) begin
                    state_d = StStretch;
                    scnt_d  = '0;
                end
            end
            StStretch: begin
                if (!lock_s) begin
                    state_d = StHold;
                    scnt_d  = '0;
                end else if (scnt_q == STRETCH_LAST) begin
                    state_d = StRun;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + SCW'(1);
                end
            end
            StRun: begin
                if (!lock_s) begin
                    state_d = StHold;
                    loss    = 1'b1;
                end
            end
            default: begin
                state_d = StHold;
                scnt_d  = '0;
            end
        endcase

        // A loss in the same cycle as clear_in wins over the clear
        lost_d = clear_in ? 1'b0 : lost_q;
        lcnt_d = clear_in ? 8'd0 : lcnt_q;
        if (loss) begin
            lost_d = 1'b1;
            if (lcnt_d != 8'hff) begin
                lcnt_d = lcnt_d + 8'd1;
            end
        end
    end

    // Divider channels; divisor reloads only at a period boundary or while disabled
    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        tick_d = '0;
        sq_d   = sq_q;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (state_d != StRun) begin
                cnt_d[k] = '0;
                sq_d[k]  = 1'b0;
            end else if (state_q != StRun) begin
                cnt_d[k] = '0;
                act_d[k] = div_in[k*DIV_WIDTH +: DIV_WIDTH];
                sq_d[k]  = 1'b0;
            end else if (act_q[k] == '0) begin
                cnt_d[k] = '0;
                act_d[k] = div_in[k*DIV_WIDTH +: DIV_WIDTH];
                sq_d[k]  = 1'b0;
            end else if (cnt_q[k] == act_q[k] - DIV_WIDTH'(1)) begin
                cnt_d[k]  = '0;
                act_d[k]  = div_in[k*DIV_WIDTH +: DIV_WIDTH];
                tick_d[k] = 1'b1;
                sq_d[k]   = ~sq_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + DIV_WIDTH'(1);
            end
        end
    end

    // All state, cleared asynchronously by reset_in
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            lock_sync_q <= '0;
            state_q     <= StHold;
            scnt_q      <= '0;
            reset_q     <= 1'b1;
            running_q   <= 1'b0;
            lost_q      <= 1'b0;
            lcnt_q      <= '0;
            hb_q        <= '0;
            tick_q      <= '0;
            sq_q        <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
                act_q[k] <= '0;
            end
        end else begin
            lock_sync_q <= {lock_sync_q[0], lock_in};
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            reset_q     <= (state_d != StRun);
            running_q   <= (state_d == StRun);
            lost_q      <= lost_d;
            lcnt_q      <= lcnt_d;
            hb_q        <= hb_q + HBW'(1);
            tick_q      <= tick_d;
            sq_q        <= sq_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
        end
    end

    assign reset_out         = reset_q;
    assign running_out       = running_q;
    assign lock_lost_out     = lost_q;
    assign lock_loss_cnt_out = lcnt_q;
    assign tick_out          = tick_q;
    assign sq_out            = sq_q;
    assign hb_out            = hb_q[HB_BIT];

endmodule

// File: doc/clk_rst_manager.md
Name: clk_rst_manager

Overview:
Parametrised clock-domain housekeeping block for the board top levels. It synchronises the PLL lock and generates a stretched, lock-qualified system reset. It also produces NUM_CH runtime-programmable clock-enable ticks with matching square-wave outputs, plus a heartbeat LED bit. It replaces the ad-hoc power-on reset counter and LED/clock divider logic in each board top.

Parameters:
NUM_CH, 2, number of divider channels (1..8)
DIV_WIDTH, 16, width of each channel divisor
RESET_CYCLES, 65536, cycles reset_out stays high after lock is seen (>=2)
HB_BIT, 23, free-running counter bit driven onto hb_out
USE_LOCK, 1, 1 = qualify on lock_in; 0 = lock_in ignored and treated as 1

Ports:
clk_in  input  1  system clock (PLL output)
reset_in  input  1  asynchronous, active-high reset
lock_in  input  1  PLL lock, asynchronous to clk_in
clear_in  input  1  synchronous clear of lock_lost_out and lock_loss_cnt_out
div_in  input  NUM_CH*DIV_WIDTH  channel k divisor in bits [k*DIV_WIDTH +: DIV_WIDTH]; 0 disables the channel
reset_out  output  1  active-high system reset for downstream logic
running_out  output  1  high in RUN state
lock_lost_out  output  1  sticky: lock dropped while in RUN
lock_loss_cnt_out  output  8  saturating count of lock losses in RUN
tick_out  output  NUM_CH  one-cycle enable pulse per channel period
sq_out  output  NUM_CH  50% square wave, period 2*divisor
hb_out  output  1  heartbeat (free-running counter bit HB_BIT)

Behaviour:
- Single clock; reset_in is asynchronous and active-high. All flops clear on reset_in.
- Reset values: reset_out=1; running_out=0; lock_lost_out=0; lock_loss_cnt_out=0; tick_out=0; sq_out=0; hb_out=0.
- Lock sync: 2-flop synchroniser gives lock_s; lock_s is valid 2 edges after lock_in changes. USE_LOCK=0 forces lock_s=1.
- FSM states: HOLD (reset default), STRETCH, RUN.
  - HOLD: if lock_s=1, go to STRETCH and set stretch count to 0.
  - STRETCH: if lock_s=0, go to HOLD and clear the count. Otherwise increment; when count==RESET_CYCLES-1, go to RUN.
  - RUN: if lock_s=0, go to HOLD. lock_lost_out<=1 and lock_loss_cnt_out increments, saturating at 255.
- reset_out=1 in HOLD and STRETCH; 0 only in RUN. It is registered from the state: exactly RESET_CYCLES cycles high in STRETCH before the first RUN cycle.
- running_out = (state==RUN), registered, coincident with reset_out falling.
- clear_in: clears lock_lost_out and lock_loss_cnt_out the next cycle. If clear_in and a lock loss happen in the same cycle, the loss wins: flag=1, count=1.
- Divider channel k (independent):
  - On entry to RUN: cnt_k=0, active_div_k<=div_in slice.
  - In RUN with active_div_k=D>0: cnt_k counts 0..D-1 and wraps.
  - At the edge where cnt_k==D-1: tick_out[k] is set for one cycle, sq_out[k] toggles, and active_div_k reloads from div_in. A divisor change therefore takes effect only at a period boundary, so there are no runt pulses.
  - First tick is visible in RUN cycle index D (first RUN cycle = index 0), then every D cycles.
  - D=1: tick_out[k] high every cycle; sq_out[k] toggles every cycle.
  - D=0: tick_out[k]=0, sq_out[k]=0, cnt_k=0. active_div_k reloads from div_in every cycle, so the channel starts with the new divisor on the cycle after it is written.
  - Outside RUN: cnt_k=0, tick_out=0, sq_out=0.
- Heartbeat: free-running counter of HB_BIT+1 bits, increments every cycle in all FSM states; cleared only by reset_in. hb_out = counter[HB_BIT].
- reset_in mid-operation: everything returns to reset values immediately (asynchronously); the FSM restarts in HOLD.

Test Plan:
1. RESET_CYCLES=16, lock_in=1 from t0, reset_in released -> reset_out low and running_out high exactly 2+1+16 edges after release (sync + HOLD->STRETCH + stretch); lock_lost_out=0.
2. Lock drops for 5 cycles at STRETCH count 10 -> back to HOLD, count restarts at 0; reset_out stays 1 until 16 full stretch cycles after re-lock; lock_loss_cnt_out=0.
3. In RUN, lock_in low 4 cycles, three times -> reset_out reasserts each time, lock_lost_out=1, lock_loss_cnt_out=3. clear_in pulse -> both 0; 256 losses -> count stays 255.
4. div ch0=3, ch1=1 -> tick_out[0] in RUN cycles 3,6,9; sq_out[0] period 6; tick_out[1] every cycle, sq_out[1] period 2.
5. ch0=4, div_in changed to 2 at RUN cycle 5 -> ticks at cycles 4, 8 (old period completes), then 10, 12.
6. ch0=0 for 20 cycles, then div_in=5 -> no ticks, sq_out[0]=0 while 0; first tick 6 cycles after the write; USE_LOCK=0 with lock_in=0 still reaches RUN after 16 cycles.
